// File: rtl/spi_reg_target_if.sv
// ---------------------------------------------------------------------------
// spi_reg_target_if
//
// Bundles the SPI pins and the local register-bus signals of the SPI
// register target so the design and its environment share a single port.
//
// Signals:
//   spi_sclk     SPI clock from the master (mode 0)
//   spi_ss_n     active-low target select
//   spi_mosi     master-out data, MSB first
//   spi_miso     target-out data
//   spi_miso_oe  MISO output enable
//   reg_wr_en    one-cycle write strobe
//   reg_wr_addr  write address, valid with reg_wr_en
//   reg_wr_data  write data, valid with reg_wr_en
//   reg_rd_en    one-cycle read request
//   reg_rd_addr  read address, valid with reg_rd_en
//   reg_rd_data  read data returned one clk after reg_rd_en
//   busy         high while a frame is in progress
//
// Modports:
//   slave  - the SPI register target itself
//   master - the surrounding environment (SPI master pins + register file)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface spi_reg_target_if #(
  parameter int ADDR_WIDTH = 7
);

  logic                  spi_sclk;
  logic                  spi_ss_n;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic                  spi_miso_oe;
  logic                  reg_wr_en;
  logic [ADDR_WIDTH-1:0] reg_wr_addr;
  logic [7:0]            reg_wr_data;
  logic                  reg_rd_en;
  logic [ADDR_WIDTH-1:0] reg_rd_addr;
  logic [7:0]            reg_rd_data;
  logic                  busy;

  // The target samples the SPI pins and read data, and drives everything else
  modport slave (
    input  spi_sclk, spi_ss_n, spi_mosi, reg_rd_data,
    output spi_miso, spi_miso_oe, reg_wr_en, reg_wr_addr, reg_wr_data,
           reg_rd_en, reg_rd_addr, busy
  );

  // The environment drives the SPI pins and read data, and observes the rest
  modport master (
    output spi_sclk, spi_ss_n, spi_mosi, reg_rd_data,
    input  spi_miso, spi_miso_oe, reg_wr_en, reg_wr_addr, reg_wr_data,
           reg_rd_en, reg_rd_addr, busy
  );

endinterface

// File: rtl/spi_reg_target.sv
// ---------------------------------------------------------------------------
// spi_reg_target
//
// SPI mode-0 target that gives an external SPI master byte-addressed access
// to a register space in fabric. All SPI pins are oversampled in the system
// clock domain. A frame starts when ss_n falls; the first byte is the
// command {rw, addr}, every further byte is data. Writes become one-cycle
// strobes on the local bus; reads issue one-cycle read requests whose data
// is returned one clk later and shifted out on MISO during the next byte.
// The address auto-increments after each data byte and wraps at
// 2^ADDR_WIDTH.
//
// Parameters:
//   ADDR_WIDTH   register address width (at most 7)
//   SYNC_STAGES  synchronizer depth on sclk, ss_n and mosi (at least 2)
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    spi_reg_target_if.slave: SPI pins plus local register bus
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_reg_target #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  spi_reg_target_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_ssSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkPrev;
  logic                   r_ssPrev;

  logic                   w_sclkSync;
  logic                   w_ssSync;
  logic                   w_mosiSync;
  logic                   w_ssFall;
  logic                   w_ssRise;
  logic                   w_active;
  logic                   w_sclkRise;
  logic                   w_sclkFall;
  logic                   w_byteDone;
  logic                   w_frameStart;
  logic [7:0]             w_rxByte;
  logic [ADDR_WIDTH-1:0]  w_cmdAddr;
  logic [ADDR_WIDTH-1:0]  w_addrNext;

  logic [2:0]             r_bitCnt;
  logic [6:0]             r_rxShift;
  logic [7:0]             r_tx;
  logic                   r_miso;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_wrEn;
  logic [ADDR_WIDTH-1:0]  r_wrAddr;
  logic [7:0]             r_wrData;
  logic                   r_rdEn;
  logic [ADDR_WIDTH-1:0]  r_rdAddr;

  // Synchronizers for the three SPI inputs. Every stage resets low, so
  // after a reset the ss_n line has to be seen high before a fall can be
  // detected: a reset in the middle of a frame keeps the target idle until
  // the master deselects and reselects it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sclkSync <= '0;
      r_ssSync   <= '0;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
      r_ssPrev   <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], bus.spi_sclk};
      r_ssSync   <= {r_ssSync[SYNC_STAGES-2:0],   bus.spi_ss_n};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.spi_mosi};
      r_sclkPrev <= w_sclkSync;
      r_ssPrev   <= w_ssSync;
    end
  end

  // Edge detection on the last two synchronized samples. SCLK edges only
  // count while a frame is open and the synchronized select is low, so
  // clock activity aimed at other targets is ignored.
  always_comb begin
    w_sclkSync   = r_sclkSync[SYNC_STAGES-1];
    w_ssSync     = r_ssSync[SYNC_STAGES-1];
    w_mosiSync   = r_mosiSync[SYNC_STAGES-1];
    w_ssFall     = r_ssPrev & ~w_ssSync;
    w_ssRise     = ~r_ssPrev & w_ssSync;
    w_active     = (r_state != IDLE) & ~w_ssSync;
    w_sclkRise   = w_active & w_sclkSync & ~r_sclkPrev;
    w_sclkFall   = w_active & ~w_sclkSync & r_sclkPrev;
    w_byteDone   = w_sclkRise & (r_bitCnt == 3'd7);
    w_frameStart = (r_state == IDLE) & w_ssFall;
    w_rxByte     = {r_rxShift, w_mosiSync};
    w_cmdAddr    = w_rxByte[ADDR_WIDTH-1:0];
    w_addrNext   = r_addr + ADDR_ONE;
  end

  // State register of the frame FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: the command byte selects the read or write data
  // phase, and a detected rise of ss_n closes the frame from any state.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_ssFall) begin
          w_nextState = CMD;
        end
      end
      CMD: begin
        if (w_ssRise) begin
          w_nextState = IDLE;
        end else if (w_byteDone) begin
          w_nextState = w_rxByte[7] ? RDATA : WDATA;
        end
      end
      WDATA, RDATA: begin
        if (w_ssRise) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Output logic of the FSM. MISO carries data only in the read data
  // phase; during the command byte and write data it is held low.
  always_comb begin
    bus.busy        = (r_state != IDLE);
    bus.spi_miso_oe = (r_state != IDLE);
    bus.spi_miso    = (r_state == RDATA) ? r_miso : 1'b0;
  end

  // Receive path and bus strobes. Bits are shifted in on each detected
  // SCLK rise; the 8th rise completes a byte and, depending on the phase,
  // loads the address, issues a write strobe, or issues a read request
  // (for the command address, or as a prefetch of the next address).
  // Strobes are single-cycle, and a byte that was completed still issues
  // its strobe even if ss_n is seen rising in the same clk, because the
  // strobe registers do not depend on the next state. A partial byte
  // simply never reaches the 8th rise and is lost when the frame closes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bitCnt  <= 3'd0;
      r_rxShift <= 7'd0;
      r_addr    <= '0;
      r_wrEn    <= 1'b0;
      r_wrAddr  <= '0;
      r_wrData  <= 8'd0;
      r_rdEn    <= 1'b0;
      r_rdAddr  <= '0;
    end else begin
      r_wrEn <= 1'b0;
      r_rdEn <= 1'b0;
      if (w_frameStart) begin
        r_bitCnt  <= 3'd0;
        r_rxShift <= 7'd0;
      end else if (w_sclkRise) begin
        r_bitCnt  <= r_bitCnt + 3'd1;
        r_rxShift <= w_rxByte[6:0];
        if (w_byteDone) begin
          case (r_state)
            CMD: begin
              r_addr <= w_cmdAddr;
              if (w_rxByte[7]) begin
                r_rdEn   <= 1'b1;
                r_rdAddr <= w_cmdAddr;
              end
            end
            WDATA: begin
              r_wrEn   <= 1'b1;
              r_wrAddr <= r_addr;
              r_wrData <= w_rxByte;
              r_addr   <= w_addrNext;
            end
            RDATA: begin
              r_addr   <= w_addrNext;
              r_rdEn   <= 1'b1;
              r_rdAddr <= w_addrNext;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  // Transmit path. Read data is captured one clk after the read request.
  // MISO is a separate output stage updated on detected SCLK falls: the
  // first fall after a byte completes presents the MSB of the freshly
  // loaded byte, and each further fall presents the next bit, so the
  // master sees every bit stable across its sampling rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx   <= 8'd0;
      r_miso <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_tx   <= 8'd0;
        r_miso <= 1'b0;
      end else if (r_rdEn) begin
        r_tx <= bus.reg_rd_data;
      end else if (w_sclkFall && (r_state == RDATA)) begin
        r_miso <= r_tx[7];
        r_tx   <= {r_tx[6:0], 1'b0};
      end
    end
  end

  // Register-bus outputs come straight from their registers.
  assign bus.reg_wr_en   = r_wrEn;
  assign bus.reg_wr_addr = r_wrAddr;
  assign bus.reg_wr_data = r_wrData;
  assign bus.reg_rd_en   = r_rdEn;
  assign bus.reg_rd_addr = r_rdAddr;

endmodule

// File: tb/tb_spi_reg_target.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_target
//
// Self-checking bench for spi_reg_target. Acts as the SPI master and as a
// register file whose read data is the inverted address. Expected bus
// activity and MISO bytes for every frame come from a frame-level model
// built from the frame rules (address, direction, auto-increment, wrap).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_reg_target;

  localparam int AW   = 7;
  localparam int SYNC = 2;
  localparam int HALF = 10;

  logic clk = 1'b0;
  logic reset;

  spi_reg_target_if #(.ADDR_WIDTH(AW)) bus ();

  spi_reg_target #(
    .ADDR_WIDTH (AW),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // 50 MHz system clock
  always #10 clk = ~clk;

  // Register file model: every address reads back as its own inverse
  assign bus.reg_rd_data = ~{1'b0, bus.reg_rd_addr};

  int checks = 0;
  int errors = 0;

  int wrLog[$];
  int rdLog[$];
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];

  // Log every strobe cycle; a strobe stuck high shows up as extra entries
  always @(negedge clk) begin
    if (bus.reg_wr_en) wrLog.push_back(int'({bus.reg_wr_addr, bus.reg_wr_data}));
    if (bus.reg_rd_en) rdLog.push_back(int'(bus.reg_rd_addr));
  end

  // Safety net so the run always ends on its own
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Shift nBits of b out on MOSI, MSB first, capturing MISO before each rise
  task automatic spiBits(input logic [7:0] b, input int nBits, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 0; i < nBits; i++) begin
      bus.spi_mosi = b[7-i];
      waitClk(HALF);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_sclk = 1'b1;
      waitClk(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic ssLow();
    bus.spi_ss_n = 1'b0;
    waitClk(6);
  endtask

  task automatic ssHigh();
    waitClk(HALF);
    bus.spi_ss_n = 1'b1;
    waitClk(8);
  endtask

  task automatic clearLogs();
    wrLog.delete();
    rdLog.delete();
    rxQ.delete();
  endtask

  // Send the whole frame held in txQ
  task automatic applyStimulus(input string name);
    logic [7:0] rx;
    clearLogs();
    ssLow();
    checkOutput({name, "_busyOpen"}, 32'(bus.busy), 32'd1);
    foreach (txQ[i]) begin
      spiBits(txQ[i], 8, rx);
      rxQ.push_back(rx);
    end
    ssHigh();
  endtask

  // Frame-level model: compare logged strobes and MISO bytes with the
  // activity the frame in txQ must produce
  task automatic checkFrame(input string name);
    int addr;
    int n;
    bit isRead;
    int expWr[$];
    int expRd[$];
    logic [7:0] a8;
    logic [7:0] expMiso;
    isRead = txQ[0][7];
    addr   = int'(txQ[0]) % (1 << AW);
    n      = txQ.size() - 1;
    for (int k = 0; k < n; k++) begin
      if (!isRead) expWr.push_back(((addr + k) % (1 << AW)) * 256 + int'(txQ[k+1]));
    end
    if (isRead) begin
      for (int k = 0; k <= n; k++) expRd.push_back((addr + k) % (1 << AW));
    end
    checkOutput({name, "_wrCount"}, 32'(wrLog.size()), 32'(expWr.size()));
    checkOutput({name, "_rdCount"}, 32'(rdLog.size()), 32'(expRd.size()));
    foreach (expWr[i]) begin
      if (i < wrLog.size()) checkOutput({name, "_wr"}, 32'(wrLog[i]), 32'(expWr[i]));
    end
    foreach (expRd[i]) begin
      if (i < rdLog.size()) checkOutput({name, "_rd"}, 32'(rdLog[i]), 32'(expRd[i]));
    end
    for (int k = 0; k <= n; k++) begin
      if (k == 0 || !isRead) begin
        expMiso = 8'd0;
      end else begin
        a8      = 8'((addr + k - 1) % (1 << AW));
        expMiso = ~a8;
      end
      checkOutput({name, "_miso"}, 32'(rxQ[k]), 32'(expMiso));
    end
    checkOutput({name, "_busyClosed"}, 32'(bus.busy), 32'd0);
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.spi_miso, bus.spi_miso_oe, bus.reg_wr_en, bus.reg_wr_addr,
                bus.reg_wr_data, bus.reg_rd_en, bus.reg_rd_addr, bus.busy});
  endfunction

  initial begin
    logic [7:0] rx;
    int nData;

    reset        = 1'b1;
    bus.spi_ss_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    waitClk(3);
    checkOutput("resetOutputs", allOutputs(), 32'd0);
    reset = 1'b0;
    waitClk(6);

    // Single write
    txQ = '{8'h05, 8'hA5};
    applyStimulus("single");
    checkFrame("single");

    // Burst write wrapping from the top address to 0
    txQ = '{8'h7F, 8'h11, 8'h22};
    applyStimulus("wrap");
    checkFrame("wrap");

    // Burst read with prefetch
    txQ = '{8'h83, 8'h00, 8'h00};
    applyStimulus("read");
    checkFrame("read");

    // Abort after 4 bits of a data byte, then a clean frame
    clearLogs();
    ssLow();
    spiBits(8'h20, 8, rx);
    spiBits(8'hFF, 4, rx);
    ssHigh();
    checkOutput("abort_wrCount", 32'(wrLog.size()), 32'd0);
    checkOutput("abort_rdCount", 32'(rdLog.size()), 32'd0);
    txQ = '{8'h10, 8'h3C};
    applyStimulus("afterAbort");
    checkFrame("afterAbort");

    // Reset in the middle of a data byte
    clearLogs();
    ssLow();
    spiBits(8'h40, 8, rx);
    spiBits(8'hAA, 3, rx);
    reset = 1'b1;
    #1;
    checkOutput("midReset_outputs", allOutputs(), 32'd0);
    waitClk(2);
    reset = 1'b0;
    spiBits(8'h55, 5, rx);
    spiBits(8'h99, 8, rx);
    checkOutput("midReset_busy", 32'(bus.busy), 32'd0);
    ssHigh();
    checkOutput("midReset_wrCount", 32'(wrLog.size()), 32'd0);
    checkOutput("midReset_rdCount", 32'(rdLog.size()), 32'd0);
    txQ = '{8'h01, 8'h55};
    applyStimulus("afterReset");
    checkFrame("afterReset");

    // SCLK activity with ss_n high must be ignored
    clearLogs();
    for (int i = 0; i < 16; i++) begin
      bus.spi_mosi = 1'($urandom_range(0, 1));
      waitClk(HALF);
      bus.spi_sclk = ~bus.spi_sclk;
    end
    bus.spi_sclk = 1'b0;
    waitClk(HALF);
    checkOutput("deselected_oe", 32'(bus.spi_miso_oe), 32'd0);
    checkOutput("deselected_busy", 32'(bus.busy), 32'd0);
    checkOutput("deselected_strobes", 32'(wrLog.size() + rdLog.size()), 32'd0);

    // Output enable follows ss_n after SYNC_STAGES+1 clk
    bus.spi_ss_n = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1;
    checkOutput("oe_early", 32'(bus.spi_miso_oe), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("oe_on", 32'(bus.spi_miso_oe), 32'd1);
    waitClk(2);
    bus.spi_ss_n = 1'b1;
    waitClk(8);
    checkOutput("oe_off", 32'(bus.spi_miso_oe), 32'd0);

    // Randomized frames
    for (int t = 0; t < 8; t++) begin
      txQ.delete();
      txQ.push_back(8'($urandom));
      nData = $urandom_range(1, 4);
      for (int k = 0; k < nData; k++) txQ.push_back(8'($urandom));
      applyStimulus("random");
      checkFrame("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
